// File: rtl/thermometer_ramp_ctrl_if.sv
// Target-command and level-status bundle for thermometer_ramp_ctrl.
// The master issues targets; the slave (the controller) returns level and status.
interface thermometer_ramp_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned LW = $clog2(WIDTH + 1);

    logic              tgt_vld;
    logic              tgt_rdy;
    logic [LW-1:0]     tgt;
    logic [LW-1:0]     level;
    logic [WIDTH-1:0]  thermometer;
    logic              busy;
    logic              done;

    modport master (
        output tgt_vld, tgt,
        input  tgt_rdy, level, thermometer, busy, done
    );

    modport slave (
        input  tgt_vld, tgt,
        output tgt_rdy, level, thermometer, busy, done
    );
endinterface

// File: rtl/thermometer_ramp_ctrl.sv
// Ramps a WIDTH-element thermometer actuator one element per STEP_DIV cycles toward a target.
// Define THERMO_RAMP_ROTATE_EN for data-weighted element rotation instead of fill-from-bit-0.
module thermometer_ramp_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned STEP_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    thermometer_ramp_ctrl_if.slave bus
);
    localparam int unsigned LW = $clog2(WIDTH + 1);
    localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LW-1:0]     level_q, level_d;
    logic [WIDTH-1:0]  therm_q, therm_d;
    logic [LW-1:0]     target_q, target_d;
    logic              up_q, up_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LW-1:0]     tgt_sat_c;
    logic              accept_c;

`ifdef THERMO_RAMP_ROTATE_EN
    localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     ptr_inc_c;
    logic [LW:0]       sum_c;
    logic [LW:0]       idx_c;

    // Element just above the active wrapped range, and the pointer after a step down.
    always_comb begin
        sum_c     = (LW+1)'(ptr_q) + (LW+1)'(level_q);
        idx_c     = (sum_c >= (LW+1)'(WIDTH)) ? sum_c - (LW+1)'(WIDTH) : sum_c;
        ptr_inc_c = (ptr_q == PW'(WIDTH - 1)) ? '0 : ptr_q + PW'(1);
    end
`else
    function automatic logic [WIDTH-1:0] therm_fill(input logic [LW-1:0] lvl);
        logic [WIDTH-1:0] f;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            f[i] = (LW'(i) < lvl);
        end
        return f;
    endfunction
`endif

    assign bus.tgt_rdy     = (state_q == IDLE) && !rst;
    assign accept_c        = bus.tgt_vld && bus.tgt_rdy;
    assign tgt_sat_c       = (bus.tgt > LW'(WIDTH)) ? LW'(WIDTH) : bus.tgt;
    assign bus.level       = level_q;
    assign bus.thermometer = therm_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        therm_d  = therm_q;
        target_d = target_q;
        up_d     = up_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef THERMO_RAMP_ROTATE_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (tgt_sat_c == level_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RAMP;
                        cnt_d    = '0;
                        target_d = tgt_sat_c;
                        up_d     = (tgt_sat_c > level_q);
                        busy_d   = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (cnt_q == CW'(STEP_DIV - 1)) begin
                    cnt_d   = '0;
                    level_d = up_q ? level_q + LW'(1) : level_q - LW'(1);
`ifdef THERMO_RAMP_ROTATE_EN
                    if (up_q) begin
                        therm_d[PW'(idx_c)] = 1'b1;
                    end else begin
                        therm_d[ptr_q] = 1'b0;
                        ptr_d          = ptr_inc_c;
                    end
`else
                    therm_d = therm_fill(level_d);
`endif
                    if (level_d == target_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            level_q  <= '0;
            therm_q  <= '0;
            target_q <= '0;
            up_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef THERMO_RAMP_ROTATE_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            therm_q  <= therm_d;
            target_q <= target_d;
            up_q     <= up_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef THERMO_RAMP_ROTATE_EN
            ptr_q    <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_thermometer_ramp_ctrl.sv
// Directed bench for thermometer_ramp_ctrl: three instances (8/4, 5/1, 8/1) share clock and reset.
module tb_thermometer_ramp_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       drv_vld = 1'b0;
    logic [3:0] drv_tgt = '0;
    int         sel = 0;

    int         o_level;
    logic [7:0] o_therm;
    logic       o_busy, o_done, o_rdy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    thermometer_ramp_ctrl_if #(.WIDTH(8)) ia ();
    thermometer_ramp_ctrl_if #(.WIDTH(5)) ib ();
    thermometer_ramp_ctrl_if #(.WIDTH(8)) ic ();

    thermometer_ramp_ctrl #(.WIDTH(8), .STEP_DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    thermometer_ramp_ctrl #(.WIDTH(5), .STEP_DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    thermometer_ramp_ctrl #(.WIDTH(8), .STEP_DIV(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    assign ia.tgt_vld = drv_vld && (sel == 0);
    assign ib.tgt_vld = drv_vld && (sel == 1);
    assign ic.tgt_vld = drv_vld && (sel == 2);
    assign ia.tgt     = drv_tgt;
    assign ib.tgt     = drv_tgt[2:0];
    assign ic.tgt     = drv_tgt;

    always_comb begin
        o_level = int'(ia.level);
        o_therm = ia.thermometer;
        o_busy  = ia.busy;
        o_done  = ia.done;
        o_rdy   = ia.tgt_rdy;
        if (sel == 1) begin
            o_level = int'(ib.level);
            o_therm = {3'b000, ib.thermometer};
            o_busy  = ib.busy;
            o_done  = ib.done;
            o_rdy   = ib.tgt_rdy;
        end else if (sel == 2) begin
            o_level = int'(ic.level);
            o_therm = ic.thermometer;
            o_busy  = ic.busy;
            o_done  = ic.done;
            o_rdy   = ic.tgt_rdy;
        end
    end

    typedef struct {
        int sel;
        int t;
        int edges;
        int lvl;
        int th;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int s, input int t, input int e, input int l, input int th);
        vec_t v;
        v.sel = s; v.t = t; v.edges = e; v.lvl = l; v.th = th;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Accept one target, wait for done, and check timing and final outputs.
    task automatic xact(input string nm, input int t, input int e, input int l, input int th);
        int n;
        drv_tgt = 4'(t);
        drv_vld = 1'b1;
        tick();
        drv_vld = 1'b0;
        chk({nm, "_busy_first"}, int'(o_busy), (e != 0) ? 1 : 0);
        n = 0;
        while (!o_done && n < 100) begin
            tick();
            n++;
        end
        chk({nm, "_edges"}, n, e);
        chk({nm, "_level"}, o_level, l);
        chk({nm, "_therm"}, int'(o_therm), th);
        chk({nm, "_busy_end"}, int'(o_busy), 0);
        chk({nm, "_rdy_end"}, int'(o_rdy), 1);
        tick();
        chk({nm, "_done_next"}, int'(o_done), 0);
    endtask

    initial begin
        int n;

        // 8 elements, 4 cycles per step
        add(0,  5, 20, 5, 'h1F);
        add(0,  2, 12, 2, 'h03);
        add(0,  2,  0, 2, 'h03);
        add(0,  0,  8, 0, 'h00);
        add(0, 15, 32, 8, 'hFF);
        add(0,  3, 20, 3, 'h07);
        add(0,  3,  0, 3, 'h07);
        add(0,  5,  8, 5, 'h1F);
        // 5 elements, one step per cycle
        add(1,  5,  5, 5, 'h1F);
        add(1,  0,  5, 0, 'h00);
        add(1,  7,  5, 5, 'h1F);
        add(1,  3,  2, 3, 'h07);
        add(1,  3,  0, 3, 'h07);
        // 8 elements, one step per cycle; element placement depends on rotation
`ifdef THERMO_RAMP_ROTATE_EN
        add(2, 3, 3, 3, 'h07);
        add(2, 1, 2, 1, 'h04);
        add(2, 4, 3, 4, 'h3C);
        add(2, 8, 4, 8, 'hFF);
        add(2, 6, 2, 6, 'hF3);
`else
        add(2, 3, 3, 3, 'h07);
        add(2, 1, 2, 1, 'h01);
        add(2, 4, 3, 4, 'h0F);
        add(2, 8, 4, 8, 'hFF);
        add(2, 6, 2, 6, 'h3F);
`endif

        // Power-on reset
        sel = 0;
        tick();
        chk("rst_rdy_low", int'(o_rdy), 0);
        tick();
        tick();
        chk("rst_level", o_level, 0);
        chk("rst_therm", int'(o_therm), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        rst = 1'b0;
        #1;
        chk("rst_rdy_high", int'(o_rdy), 1);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            xact($sformatf("vec%0d", i), vecs[i].t, vecs[i].edges, vecs[i].lvl, vecs[i].th);
        end

        // Ramp 5->2 with a held request for 7 that is accepted only once ready returns
        sel = 0;
        drv_tgt = 4'd2;
        drv_vld = 1'b1;
        tick();
        drv_tgt = 4'd7;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk($sformatf("hold_level_e%0d", e), o_level, 5 - e / 4);
            if (e == 11) chk("hold_rdy_e11", int'(o_rdy), 0);
        end
        chk("hold_done_e12", int'(o_done), 1);
        chk("hold_rdy_e12", int'(o_rdy), 1);
        chk("hold_therm_e12", int'(o_therm), 'h03);
        tick();
        drv_vld = 1'b0;
        chk("hold_accept_busy", int'(o_busy), 1);
        chk("hold_accept_done", int'(o_done), 0);
        chk("hold_accept_rdy", int'(o_rdy), 0);
        n = 0;
        while (!o_done && n < 100) begin
            tick();
            n++;
        end
        chk("hold_second_edges", n, 20);
        chk("hold_second_level", o_level, 7);
        chk("hold_second_therm", int'(o_therm), 'h7F);
        tick();

        // Reset in the middle of a 7->0 ramp at level 3
        drv_tgt = 4'd0;
        drv_vld = 1'b1;
        tick();
        drv_vld = 1'b0;
        repeat (16) tick();
        chk("midrst_level_before", o_level, 3);
        rst = 1'b1;
        tick();
        chk("midrst_level", o_level, 0);
        chk("midrst_therm", int'(o_therm), 0);
        chk("midrst_busy", int'(o_busy), 0);
        chk("midrst_done", int'(o_done), 0);
        chk("midrst_rdy", int'(o_rdy), 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_rdy_after", int'(o_rdy), 1);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (o_done || o_busy || o_level != 0) n++;
        end
        chk("midrst_discarded", n, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
